// File: rtl/wb_arb_pkg.sv
// Shared types and sizes for the writeback arbiter.
// Included by the arbiter top and its decoder.
package wb_arb_pkg;

    localparam int REG_AW = 4;
    localparam int NREGS  = 16;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_M = 1'b1
    } pri_t;

endpackage

// File: rtl/wb_arb16_dec1to16.sv
// 4-to-16 one-hot decoder with enable.
// Drives the register-file write enables.
module dec1to16
    import wb_arb_pkg::*;
(
    input  logic              en,
    input  logic [REG_AW-1:0] sel,
    output logic [NREGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arb16.sv
// Two-port writeback arbiter (ALU / memory) for a 16-entry register file.
// Alternating priority under contention, one registered write per cycle.
module wb_arb16
    import wb_arb_pkg::*;
#(
    parameter int DW      = 16,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              valid_a,
    input  logic [REG_AW-1:0] addr_a,
    input  logic [DW-1:0]     data_a,
    input  logic              valid_m,
    input  logic [REG_AW-1:0] addr_m,
    input  logic [DW-1:0]     data_m,
    output logic              ready_a,
    output logic              ready_m,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_sel,
    output logic [NREGS-1:0]  wr_onehot,
    output logic [DW-1:0]     wr_data,
    output logic [7:0]        coll_cnt
);

    pri_t              pri;
    logic              open;
    logic              grant;
    logic              contend;
    logic              discard;
    logic [REG_AW-1:0] g_addr;
    logic [DW-1:0]     g_data;

    assign open    = rst_n && !hold;
    assign contend = open && valid_a && valid_m;

    assign ready_a = open && valid_a
                  && (!valid_m || pri == PRI_A);
    assign ready_m = open && valid_m
                  && (!valid_a || pri == PRI_M);

    assign grant  = ready_a || ready_m;
    assign g_addr = ready_a ? addr_a : addr_m;
    assign g_data = ready_a ? data_a : data_m;

    // A granted write to r0 is consumed but never reaches the file.
    assign discard = ZERO_R0 && (g_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pri      <= PRI_A;
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            wr_data  <= '0;
            coll_cnt <= '0;
        end else begin
            wr_en <= grant && !discard;
            if (grant) begin
                pri <= ready_a ? PRI_M : PRI_A;
            end
            if (grant && !discard) begin
                wr_sel  <= g_addr;
                wr_data <= g_data;
            end
            if (contend && coll_cnt != 8'hFF) begin
                coll_cnt <= coll_cnt + 8'd1;
            end
        end
    end

    dec1to16 u_dec (
        .en     (wr_en),
        .sel    (wr_sel),
        .onehot (wr_onehot)
    );

endmodule
